// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL lock sequencer.
//   seq_state_e  : 3-bit sequencer state encoding, also used by the status
//                  register map (PLL_RESET=0 .. FAULT=4)
//   DEF_*        : default timing constants for a 10 MHz reference clock
//   max3         : helper used to size the shared state timer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_RST_CYCLES    = 10;     // 1 us at 10 MHz
  localparam int DEF_LOCK_TIMEOUT  = 10000;  // 1 ms at 10 MHz
  localparam int DEF_STABLE_CYCLES = 1000;   // 100 us at 10 MHz
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_MAX_RETRIES   = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit
// Generic single-bit synchroniser: STAGES flops in series, all cleared by
// the synchronous reset. Used for the PLL lock input and other status
// crossings into the reference-clock domain.
// Ports:
//   clk  : destination clock
//   rst  : synchronous active-high reset (clears every stage to 0)
//   d    : asynchronous input bit
//   q    : synchronised output (last stage)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  // Stage 0 is the only flop allowed to go metastable; later stages
  // give it time to resolve before anything downstream uses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Reset/lock sequencer sitting directly downstream of the board PLL, run
// from the free-running reference clock. Pulses the PLL reset, qualifies
// the (synchronised) lock indication, holds the fabric reset until lock
// has been stable long enough, and re-resets the PLL on timeout or loss
// of lock while counting those events.
//
// Optional feature, enabled by defining PLL_SEQ_RETRY_LIMIT_EN:
//   after MAX_RETRIES consecutive lock timeouts the sequencer parks in
//   FAULT (PLL held in reset) until rst or sw_pll_reset. Without the macro
//   it retries forever and MAX_RETRIES is ignored.
//
// Ports:
//   refclk       : reference clock (10 MHz nominal)
//   rst          : synchronous active-high reset
//   pll_locked   : PLL lock output, asynchronous to refclk
//   sw_pll_reset : single-cycle software request to re-reset the PLL
//   pll_rst      : PLL reset, active-high (PLL_RESET and FAULT)
//   sys_rst      : fabric reset request, low only in RUN
//   ready        : high only in RUN
//   retry_count  : saturating count of lock timeouts since rst
//   loss_count   : saturating count of lock losses from RUN since rst
//   seq_state    : current state encoding for the status register
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             sw_pll_reset,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       seq_state
);

  // Shared timer counts cycles spent in the current state; it must reach
  // the largest "last cycle" index of any timed state.
  localparam int TIMER_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX    = '1;
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;

  // Parameter sanity: a single-flop synchroniser is not safe, and a retry
  // limit of zero would make the limit meaningless.
  if (SYNC_STAGES < 2 || MAX_RETRIES < 1 || RST_CYCLES < 1 ||
      LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_param_check
    $error("pll_lock_sequencer: illegal parameter value");
  end

  logic locked_s;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  seq_state_e       state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0]   retry_count_reg, retry_count_next;
  logic [CNT_W-1:0]   loss_count_reg, loss_count_next;
  logic               pll_rst_reg, pll_rst_next;
  logic               sys_rst_reg, sys_rst_next;
  logic               ready_reg, ready_next;
  logic               timer_restart;
  logic               retry_inc;
  logic               loss_inc;

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  localparam int CONSEC_W = $clog2(MAX_RETRIES + 1);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_RETRIES);

  logic [CONSEC_W-1:0] consec_reg, consec_next;
  logic                consec_clr;
  logic                consec_inc;
  logic                limit_hit;

  // True when the timeout being taken now is the MAX_RETRIES-th in a row.
  assign limit_hit = (int'(consec_reg) + 1) >= MAX_RETRIES;
`endif

  always_comb begin
    state_next    = state_reg;
    timer_restart = 1'b0;
    retry_inc     = 1'b0;
    loss_inc      = 1'b0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    consec_clr    = 1'b0;
    consec_inc    = 1'b0;
`endif

    if (sw_pll_reset) begin
      // Software request beats everything except rst; the timer is forced
      // to zero even when already in PLL_RESET so the pulse restarts.
      state_next    = ST_PLL_RESET;
      timer_restart = 1'b1;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
      consec_clr    = 1'b1;
`endif
    end else begin
      case (state_reg)
        ST_PLL_RESET: begin
          if (timer_reg == RST_LAST) begin
            state_next = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked first so a lock arriving in the timeout cycle wins.
          if (locked_s) begin
            state_next = ST_STABILIZE;
          end else if (timer_reg == TIMEOUT_LAST) begin
            retry_inc  = 1'b1;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            consec_inc = 1'b1;
            state_next = limit_hit ? ST_FAULT : ST_PLL_RESET;
`else
            state_next = ST_PLL_RESET;
`endif
          end
        end
        ST_STABILIZE: begin
          if (!locked_s) begin
            state_next = ST_WAIT_LOCK;
          end else if (timer_reg == STABLE_LAST) begin
            state_next = ST_RUN;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            consec_clr = 1'b1;
`endif
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_next = ST_PLL_RESET;
            loss_inc   = 1'b1;
          end
        end
        ST_FAULT: begin
`ifdef PLL_SEQ_RETRY_LIMIT_EN
          state_next = ST_FAULT;
`else
          state_next = ST_PLL_RESET;
`endif
        end
        default: begin
          state_next = ST_PLL_RESET;
        end
      endcase
    end

    // Timer clears on any transition or restart; it saturates rather than
    // wrapping while parked in RUN or FAULT.
    if (timer_restart || (state_next != state_reg)) begin
      timer_next = '0;
    end else if (timer_reg == TIMER_MAX) begin
      timer_next = timer_reg;
    end else begin
      timer_next = timer_reg + TIMER_W'(1);
    end

    retry_count_next = retry_count_reg;
    if (retry_inc && (retry_count_reg != CNT_MAX)) begin
      retry_count_next = retry_count_reg + CNT_W'(1);
    end

    loss_count_next = loss_count_reg;
    if (loss_inc && (loss_count_reg != CNT_MAX)) begin
      loss_count_next = loss_count_reg + CNT_W'(1);
    end

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    consec_next = consec_reg;
    if (consec_clr) begin
      consec_next = '0;
    end else if (consec_inc && (consec_reg != CONSEC_MAX)) begin
      consec_next = consec_reg + CONSEC_W'(1);
    end
`endif

    // Outputs are decoded from the next state and registered, so they are
    // glitch-free and change together with the state register.
    pll_rst_next = (state_next == ST_PLL_RESET) || (state_next == ST_FAULT);
    sys_rst_next = (state_next != ST_RUN);
    ready_next   = (state_next == ST_RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg       <= ST_PLL_RESET;
      timer_reg       <= '0;
      retry_count_reg <= '0;
      loss_count_reg  <= '0;
      pll_rst_reg     <= 1'b1;
      sys_rst_reg     <= 1'b1;
      ready_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      retry_count_reg <= retry_count_next;
      loss_count_reg  <= loss_count_next;
      pll_rst_reg     <= pll_rst_next;
      sys_rst_reg     <= sys_rst_next;
      ready_reg       <= ready_next;
    end
  end

`ifdef PLL_SEQ_RETRY_LIMIT_EN
  always_ff @(posedge refclk) begin
    if (rst) begin
      consec_reg <= '0;
    end else begin
      consec_reg <= consec_next;
    end
  end
`endif

  assign pll_rst     = pll_rst_reg;
  assign sys_rst     = sys_rst_reg;
  assign ready       = ready_reg;
  assign retry_count = retry_count_reg;
  assign loss_count  = loss_count_reg;
  assign seq_state   = state_reg;

endmodule
